// File: rtl/sdrc_app_arb_if.sv
// Shared-port bundle between the client requesters, the arbiter and the SDRAM core
// application interface. The master modport is the arbiter's view; slave is the rest.
interface sdrc_app_arb_if #(
  parameter int NREQ = 4,
  parameter int AW   = 26,
  parameter int LW   = 9,
  parameter int DW   = 32
);
  logic [NREQ-1:0]        req;
  logic [NREQ*AW-1:0]     req_addr;
  logic [NREQ*LW-1:0]     req_len;
  logic [NREQ-1:0]        req_wr_n;
  logic [NREQ*DW-1:0]     req_wr_data;
  logic [NREQ*DW/8-1:0]   req_wr_en_n;
  logic [NREQ-1:0]        req_ack;
  logic [NREQ-1:0]        wr_next;
  logic [NREQ-1:0]        last_wr;
  logic [NREQ-1:0]        rd_valid;
  logic [NREQ-1:0]        last_rd;
  logic [DW-1:0]          rd_data;
  logic [NREQ-1:0]        grant;

  logic                   app_req;
  logic [AW-1:0]          app_req_addr;
  logic [LW-1:0]          app_req_len;
  logic                   app_req_wr_n;
  logic                   app_req_ack;
  logic [DW-1:0]          app_wr_data;
  logic [DW/8-1:0]        app_wr_en_n;
  logic                   app_wr_next_req;
  logic                   app_last_wr;
  logic [DW-1:0]          app_rd_data;
  logic                   app_rd_valid;
  logic                   app_last_rd;

  modport master (
    input  req, req_addr, req_len, req_wr_n, req_wr_data, req_wr_en_n,
    input  app_req_ack, app_wr_next_req, app_last_wr, app_rd_data, app_rd_valid, app_last_rd,
    output req_ack, wr_next, last_wr, rd_valid, last_rd, rd_data, grant,
    output app_req, app_req_addr, app_req_len, app_req_wr_n, app_wr_data, app_wr_en_n
  );

  modport slave (
    output req, req_addr, req_len, req_wr_n, req_wr_data, req_wr_en_n,
    output app_req_ack, app_wr_next_req, app_last_wr, app_rd_data, app_rd_valid, app_last_rd,
    input  req_ack, wr_next, last_wr, rd_valid, last_rd, rd_data, grant,
    input  app_req, app_req_addr, app_req_len, app_req_wr_n, app_wr_data, app_wr_en_n
  );
endinterface

// File: rtl/sdrc_app_arb.sv
// Round-robin arbiter sharing one SDRAM controller application port among NREQ
// requesters; a grant is held from request through the last data beat of the burst.
module sdrc_app_arb #(
  parameter int NREQ = 4,
  parameter int AW   = 26,
  parameter int LW   = 9,
  parameter int DW   = 32
) (
  input logic            clk,
  input logic            reset,
  sdrc_app_arb_if.master bus
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int BW = DW / 8;

  typedef enum logic [1:0] {IDLE, REQ, WR, RD} state_t;

  state_t          state;
  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   owner;
  logic [NREQ-1:0] grant_q;
  logic            app_req_q;
  logic [AW-1:0]   addr_q;
  logic [LW-1:0]   len_q;
  logic            wr_n_q;

  logic [NREQ-1:0] rot;
  logic [PW-1:0]   pick_off;
  logic [PW:0]     pick_sum;
  logic [PW-1:0]   pick;
  logic [PW-1:0]   next_ptr;
  logic [AW-1:0]   sel_addr;
  logic [LW-1:0]   sel_len;
  logic            sel_wr_n;

  // Rotate requests so rr_ptr sits at bit 0; the lowest set bit is the winner.
  always_comb begin
    rot      = NREQ'({bus.req, bus.req} >> rr_ptr);
    pick_off = '0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (rot[j]) pick_off = PW'(j);
    end
    pick_sum = {1'b0, rr_ptr} + {1'b0, pick_off};
    pick     = (pick_sum >= (PW+1)'(NREQ)) ? PW'(pick_sum - (PW+1)'(NREQ)) : PW'(pick_sum);
    sel_addr = '0;
    sel_len  = '0;
    sel_wr_n = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick == PW'(i)) begin
        sel_addr = bus.req_addr[i*AW +: AW];
        sel_len  = bus.req_len[i*LW +: LW];
        sel_wr_n = bus.req_wr_n[i];
      end
    end
    next_ptr = (owner == PW'(NREQ - 1)) ? '0 : owner + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      grant_q   <= '0;
      app_req_q <= 1'b0;
      addr_q    <= '0;
      len_q     <= '0;
      wr_n_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|bus.req) begin
            state     <= REQ;
            owner     <= pick;
            grant_q   <= NREQ'(1) << pick;
            app_req_q <= 1'b1;
            addr_q    <= sel_addr;
            len_q     <= sel_len;
            wr_n_q    <= sel_wr_n;
          end
        end
        REQ: begin
          if (bus.app_req_ack) begin
            app_req_q <= 1'b0;
            state     <= wr_n_q ? RD : WR;
          end
        end
        WR: begin
          if (bus.app_wr_next_req && bus.app_last_wr) begin
            state   <= IDLE;
            grant_q <= '0;
            rr_ptr  <= next_ptr;
          end
        end
        RD: begin
          if (bus.app_rd_valid && bus.app_last_rd) begin
            state   <= IDLE;
            grant_q <= '0;
            rr_ptr  <= next_ptr;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Core strobes reach only the owner, and only in the phase they belong to.
  always_comb begin
    bus.req_ack     = '0;
    bus.wr_next     = '0;
    bus.last_wr     = '0;
    bus.rd_valid    = '0;
    bus.last_rd     = '0;
    bus.app_wr_data = '0;
    bus.app_wr_en_n = '1;
    case (state)
      REQ: begin
        if (bus.app_req_ack) bus.req_ack = grant_q;
      end
      WR: begin
        if (bus.app_wr_next_req) bus.wr_next = grant_q;
        if (bus.app_last_wr)     bus.last_wr = grant_q;
        for (int i = 0; i < NREQ; i++) begin
          if (owner == PW'(i)) begin
            bus.app_wr_data = bus.req_wr_data[i*DW +: DW];
            bus.app_wr_en_n = bus.req_wr_en_n[i*BW +: BW];
          end
        end
      end
      RD: begin
        if (bus.app_rd_valid) bus.rd_valid = grant_q;
        if (bus.app_last_rd)  bus.last_rd  = grant_q;
      end
      default: ;
    endcase
  end

  assign bus.rd_data      = bus.app_rd_data;
  assign bus.grant        = grant_q;
  assign bus.app_req      = app_req_q;
  assign bus.app_req_addr = addr_q;
  assign bus.app_req_len  = len_q;
  assign bus.app_req_wr_n = wr_n_q;
endmodule

// File: doc/sdrc_app_arb.md
Name: sdrc_app_arb

Overview:
- Round-robin arbiter that shares the single SDRAM controller application port (app_req/app_wr_*/app_rd_*) among NREQ independent requesters.
- Sits between the client masters and sdrc_core.
- Grants one requester per burst and holds the grant for the whole transaction, through the last write beat or the last read beat.
- Routes write data and enables from the granted requester to the core, and steers the core's read/write strobes back to it.

Parameters:
- NREQ, 4, number of requesters (2..8).
- AW, 26, application address width.
- LW, 9, burst length width.
- DW, 32, application data width.

Ports:
- clk  in  1  single clock, same as the sdrc_core clk.
- reset  in  1  asynchronous, active-high reset.
- req  in  NREQ  per-requester request; held high until the matching req_ack.
- req_addr  in  NREQ*AW  per-requester address; slice i = [i*AW +: AW].
- req_len  in  NREQ*LW  per-requester burst length.
- req_wr_n  in  NREQ  per-requester direction; 0 = write.
- req_wr_data  in  NREQ*DW  per-requester write data.
- req_wr_en_n  in  NREQ*DW/8  per-requester byte enables, active-low.
- req_ack  out  NREQ  one-hot request acknowledge.
- wr_next  out  NREQ  one-hot write-data-consumed strobe.
- last_wr  out  NREQ  one-hot last-write strobe.
- rd_valid  out  NREQ  one-hot read-data-valid strobe.
- last_rd  out  NREQ  one-hot last-read strobe.
- rd_data  out  DW  broadcast copy of app_rd_data.
- grant  out  NREQ  one-hot current owner; 0 when idle.
- app_req  out  1  request to the core.
- app_req_addr  out  AW  latched address of the owner.
- app_req_len  out  LW  latched length of the owner.
- app_req_wr_n  out  1  latched direction of the owner.
- app_req_ack  in  1  core acknowledge.
- app_wr_data  out  DW  owner's write data (combinational mux).
- app_wr_en_n  out  DW/8  owner's byte enables; all 1s when there is no write owner.
- app_wr_next_req  in  1  core write strobe.
- app_last_wr  in  1  core last-write strobe.
- app_rd_data  in  DW  core read data.
- app_rd_valid  in  1  core read-valid strobe.
- app_last_rd  in  1  core last-read strobe.

Behaviour:
- Reset (asynchronous, any state):
  - state = IDLE, grant = 0, rr_ptr = 0, app_req = 0.
  - app_req_addr, app_req_len, app_req_wr_n = 0.
  - All one-hot outputs = 0; app_wr_en_n = all 1s.
  - A reset in the middle of a burst abandons it; no strobes are emitted.
- States: IDLE, REQ, WR, RD.
- IDLE:
  - If any req bit is set, select the first set bit scanning rr_ptr, rr_ptr+1, ... mod NREQ.
  - On the next edge: register grant (one-hot), latch that requester's addr/len/wr_n onto the app_req_* outputs, set app_req = 1, go to REQ.
  - If no req bit is set, stay in IDLE.
- REQ:
  - app_req stays high until a cycle with app_req_ack = 1.
  - In that cycle req_ack[g] = 1 (combinational from app_req_ack & grant[g]).
  - On the following edge: app_req = 0; go to WR if app_req_wr_n = 0, else RD.
- WR:
  - app_wr_data and app_wr_en_n are muxed from requester g.
  - wr_next[g] = app_wr_next_req and last_wr[g] = app_last_wr, both combinational.
  - When app_wr_next_req & app_last_wr: go to IDLE, grant = 0, rr_ptr = (g+1) mod NREQ.
- RD:
  - rd_valid[g] = app_rd_valid, last_rd[g] = app_last_rd.
  - When app_rd_valid & app_last_rd: go to IDLE, grant = 0, rr_ptr = (g+1) mod NREQ.
- rd_data = app_rd_data in every state.
- Minimum turnaround is one IDLE cycle between bursts; arbitration latency is one cycle from req to app_req.
- Strobes arriving in the wrong state (read strobe in WR, write strobe in RD, any strobe in IDLE) are not forwarded to any requester.
- If the owner drops req while in REQ, the burst still completes; the arbiter does not cancel.
- If req is asserted for the current owner during the transfer, it is ignored until IDLE and then competes under the advanced rr_ptr.
- Simultaneous requests: the lowest index at or after rr_ptr wins; all others wait.
- Fairness: a continuously requesting master waits at most NREQ-1 bursts.

Test Plan:
- Single write: req[1]=1, addr 0x000100, len 4, wr_n 0.
  - app_req rises 1 cycle later with those values; req_ack[1] pulses with app_req_ack.
  - 4 wr_next[1] pulses; last_wr[1] on the 4th; grant returns to 0 and rr_ptr = 2.
- Single read on requester 3, len 8:
  - 8 rd_valid[3] pulses carrying app_rd_data; last_rd[3] on the 8th; no strobe on other bits.
- Round robin: req = 4'b1111 held with 1-beat bursts.
  - Grant order is 0, 1, 2, 3, 0; each grant is followed by one IDLE cycle.
- Ack stall: app_req_ack held low for 10 cycles.
  - app_req and the latched addr stay stable; req_ack stays 0 until the ack.
- Reset mid write burst (after 2 of 4 beats):
  - All outputs go to reset values immediately.
  - After release, req[2] is granted first with rr_ptr = 0 (req[0] low).
- Stray strobes: app_rd_valid pulsed in IDLE and during WR.
  - No rd_valid bit asserts and the state is unchanged.
